// File: rtl/ccd_rgb_packer.sv
// Packs demosaiced 10-bit RGB camera pixels into 32-bit words and measures frame geometry.
// One capture per enabled frame: waits for a clean start of frame, then tracks lines, rows and line-length consistency.
module ccd_rgb_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        i_fval,
  input  logic        i_lval,
  input  logic        i_dval,
  input  logic [9:0]  i_red,
  input  logic [9:0]  i_green,
  input  logic [9:0]  i_blue,
  output logic        o_data_valid,
  output logic [31:0] o_data,
  output logic [15:0] o_img_width,
  output logic [15:0] o_img_height,
  output logic        o_frame_done,
  output logic        o_line_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        prev_fval;
  logic        prev_lval;
  logic [15:0] col_cnt;
  logic [15:0] row_cnt;
  logic [15:0] ref_width;

  logic [15:0] col_next;
  logic [15:0] row_next;
  logic [15:0] ref_next;
  logic        line_err_next;

  logic        fval_rise;
  logic        fval_fall;
  logic        lval_fall;
  logic        sof;
  logic        pixel_accept;
  logic        line_end;
  logic        frame_end;
  logic [31:0] packed_pixel;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  assign fval_rise    = i_fval & ~prev_fval;
  assign fval_fall    = ~i_fval & prev_fval;
  assign lval_fall    = ~i_lval & prev_lval;
  assign sof          = (state == WAIT_SOF) && fval_rise;
  assign pixel_accept = (state == CAPTURE) && i_fval && i_lval && i_dval;
  assign line_end     = (state == CAPTURE) && lval_fall && (col_cnt != 16'd0);
  assign frame_end    = (state == CAPTURE) && fval_fall;
  assign packed_pixel = {8'h00, i_red[9:2], i_green[9:2], i_blue[9:2]};
  assign o_busy       = (state == CAPTURE);

  // NOTE: synchronous reset lives inside the clocked block, so reset_n is only seen at a clk edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        if (fval_rise) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (fval_fall) begin
          state_next = enable ? WAIT_SOF : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line end is resolved before frame end, so a final line whose lval drops with fval is still counted.
  always_comb begin
    col_next      = col_cnt;
    row_next      = row_cnt;
    ref_next      = ref_width;
    line_err_next = o_line_err;
    if (sof) begin
      col_next      = 16'd0;
      row_next      = 16'd0;
      ref_next      = 16'd0;
      line_err_next = 1'b0;
    end else if (line_end) begin
      col_next = 16'd0;
      row_next = sat_inc(row_cnt);
      if (row_cnt == 16'd0) begin
        ref_next = col_cnt;
      end else if (col_cnt != ref_width) begin
        line_err_next = 1'b1;
      end
    end else if (pixel_accept) begin
      col_next = sat_inc(col_cnt);
    end
  end

  // prev_fval resets high so a frame already running at reset release cannot look like a start of frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_fval    <= 1'b1;
      prev_lval    <= 1'b0;
      col_cnt      <= 16'd0;
      row_cnt      <= 16'd0;
      ref_width    <= 16'd0;
      o_data_valid <= 1'b0;
      o_data       <= 32'd0;
      o_img_width  <= 16'd0;
      o_img_height <= 16'd0;
      o_frame_done <= 1'b0;
      o_line_err   <= 1'b0;
    end else begin
      prev_fval    <= i_fval;
      prev_lval    <= i_lval;
      col_cnt      <= col_next;
      row_cnt      <= row_next;
      ref_width    <= ref_next;
      o_line_err   <= line_err_next;
      o_data_valid <= pixel_accept;
      o_frame_done <= frame_end;
      if (pixel_accept) begin
        o_data <= packed_pixel;
      end
      if (frame_end) begin
        o_img_width  <= ref_next;
        o_img_height <= row_next;
      end
    end
  end

endmodule

// File: doc/ccd_rgb_packer.md
CCD_RGB_PACKER -- requirements
Module: ccd_rgb_packer

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: sole clock; the pixel clock domain.
REQ-002 SHALL have port `reset_n`, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port `enable`, input, 1 bit: capture enable, sampled only at frame boundaries.
REQ-004 SHALL have port `i_fval`, input, 1 bit: frame valid.
REQ-005 SHALL have port `i_lval`, input, 1 bit: line valid.
REQ-006 SHALL have port `i_dval`, input, 1 bit: pixel valid.
REQ-007 SHALL have ports `i_red`, `i_green`, `i_blue`, input, 10 bits each: demosaiced pixel channels.
REQ-008 SHALL have port `o_data_valid`, output, 1 bit: output pixel strobe; feeds the downstream grayscale stage data_valid.
REQ-009 SHALL have port `o_data`, output, 32 bits: packed pixel; feeds the downstream grayscale stage input_data.
REQ-010 SHALL have ports `o_img_width` and `o_img_height`, output, 16 bits each: dimensions of the last completed frame.
REQ-011 SHALL have port `o_frame_done`, output, 1 bit: single-cycle end-of-frame pulse.
REQ-012 SHALL have port `o_line_err`, output, 1 bit: line-length mismatch flag for the current or last frame.
REQ-013 SHALL have port `o_busy`, output, 1 bit: high while in CAPTURE.

Function
REQ-014 SHALL implement states IDLE, WAIT_SOF and CAPTURE.
REQ-015 SHALL register previous `i_fval` and `i_lval` each cycle for edge detection.
REQ-016 SHALL make the IDLE -> WAIT_SOF transition when `enable` is 1.
REQ-017 SHALL make the WAIT_SOF -> CAPTURE transition on an fval rising edge (i_fval=1, prev_fval=0), and on that transition clear the column counter, row counter and reference width, and clear `o_line_err`.
REQ-018 SHALL treat a pixel as accepted in CAPTURE only when i_fval, i_lval and i_dval are all 1; pixels in any other state or condition SHALL be ignored.
REQ-019 SHALL, for each accepted pixel, drive `o_data_valid`=1 exactly one clk later, with `o_data` = {8'h00, i_red[9:2], i_green[9:2], i_blue[9:2]}; otherwise `o_data_valid`=0 and `o_data` holds its last value.
REQ-020 SHALL increment the column counter on each accepted pixel, saturating at 16'hFFFF.
REQ-021 SHALL treat an lval falling edge in CAPTURE with a nonzero column count as a line end; a line end with a zero column count SHALL be ignored.
REQ-022 SHALL, at each line end, clear the column counter and increment the row counter, saturating at 16'hFFFF.
REQ-023 SHALL, at a line end, load the reference width with the column count if it is the first line; otherwise it SHALL set `o_line_err` (sticky) if the column count differs from the reference width.
REQ-024 SHALL, on an fval falling edge in CAPTURE, latch `o_img_width` = reference width and `o_img_height` = row count, and pulse `o_frame_done` high for exactly 1 clk, one clk after the edge is sampled.
REQ-025 SHALL, when lval and fval fall on the same cycle, process the line end first so that the final line is counted and checked.
REQ-026 SHALL, for a frame with no accepted pixels, latch `o_img_width`=0 and `o_img_height`=0 and still pulse `o_frame_done`.
REQ-027 SHALL, after frame end, go to WAIT_SOF if `enable`=1, else to IDLE.
REQ-028 SHALL finish the current frame normally when `enable` drops mid-frame.
REQ-029 SHALL hold `o_img_width`, `o_img_height` and `o_line_err` until updated or cleared.

Reset
REQ-030 SHALL, on `reset_n`=0 sampled at a clk edge, set the state to IDLE; all counters, `o_data_valid`, `o_data`, `o_img_width`, `o_img_height`, `o_frame_done`, `o_line_err` and `o_busy` to 0; prev_lval to 0; and prev_fval to 1.
REQ-031 SHALL ignore any frame already in progress at reset release; capture SHALL begin only after a fresh fval low-to-high transition.
REQ-032 SHALL take effect identically when reset is asserted mid-frame: no partial-frame `o_frame_done` is produced.

Verification
REQ-033 SHALL be verified with: reset, enable=1, a 4x3 frame with 2-cycle lval gaps and dval held high -> 12 `o_data_valid` beats, each one clk after its input; width=4, height=3, `o_line_err`=0; one `o_frame_done` pulse.
REQ-034 SHALL be verified with: pixel R=10'h3FF, G=10'h200, B=10'h004 -> `o_data`=32'h00FF8001.
REQ-035 SHALL be verified with: enable raised while fval=1 mid-frame -> no `o_data_valid` until the next frame; the next 4x3 frame is captured fully.
REQ-036 SHALL be verified with: line lengths 4, 3, 4 -> `o_line_err`=1, width=4, height=3; the next clean frame clears `o_line_err` at SOF.
REQ-037 SHALL be verified with: lval and fval falling on the same cycle after the last pixel -> height includes that line, with exactly one `o_frame_done`.
REQ-038 SHALL be verified with: `reset_n`=0 for 1 cycle mid-frame -> all outputs 0 on the next cycle; no `o_frame_done` for the interrupted frame; the next frame is captured after fval goes low-to-high.
